// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared encodings and widths for the unified-memory arbiter
package riscv_pkg;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;
endpackage

// File: rtl/arb_prio.sv
// rtl/arb_prio.sv - LS-priority winner selection with IF anti-starvation counter
module arb_prio #(
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_en,
  input  logic if_valid,
  input  logic ls_valid,
  output logic grant_if,
  output logic grant_ls
);
  import riscv_pkg::*;

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          if_forced;

  always_comb begin
    if_forced    = if_valid && (starve_cnt_q == SMAX);
    grant_ls     = arb_en && ls_valid && !if_forced;
    grant_if     = arb_en && if_valid && !grant_ls;
    starve_cnt_d = starve_cnt_q;
    // LS can only beat a valid IF while below the limit, so the increment never wraps
    if (arb_en) begin
      if (if_valid && grant_ls) starve_cnt_d = starve_cnt_q + 1'b1;
      else                      starve_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_cnt_q <= '0;
    else        starve_cnt_q <= starve_cnt_d;
  end
endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between fetch and load/store, one transaction at a time
module mem_arbiter #(
  parameter int AW         = riscv_pkg::AW,
  parameter int DW         = riscv_pkg::DW,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req_valid,
  output logic          if_req_ready,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_rsp_valid,
  output logic [DW-1:0] if_rsp_data,
  input  logic          ls_req_valid,
  output logic          ls_req_ready,
  input  logic [AW-1:0] ls_addr,
  input  logic          ls_wren,
  input  logic [DW-1:0] ls_wdata,
  input  logic [3:0]    ls_bmask,
  output logic          ls_rsp_valid,
  output logic [DW-1:0] ls_rsp_data,
  output logic          mem_en,
  output logic          mem_wren,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_bmask,
  input  logic [DW-1:0] mem_rdata
);
  import riscv_pkg::*;

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LAT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  generate
    if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
      $fatal(1, "mem_arbiter: MEM_LAT must be in 1..4");
    end
  endgenerate

  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  owner_e        owner_q, owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wren_q, wren_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [3:0]    bmask_q, bmask_d;
  logic          flush_pending_q, flush_pending_d;

  logic rsp_cycle, arb_en, grant_if, grant_ls, accept;

  assign rsp_cycle = (state_q == WAIT) && (cnt_q == CNT_ONE);
  assign arb_en    = (state_q == IDLE) || rsp_cycle;
  assign accept    = grant_if || grant_ls;

  arb_prio #(.STARVE_MAX(STARVE_MAX)) u_arb_prio (
    .clk      (clk),
    .rst_n    (rst_n),
    .arb_en   (arb_en),
    .if_valid (if_req_valid),
    .ls_valid (ls_req_valid),
    .grant_if (grant_if),
    .grant_ls (grant_ls)
  );

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    owner_d         = owner_q;
    addr_d          = addr_q;
    wren_d          = wren_q;
    wdata_d         = wdata_q;
    bmask_d         = bmask_q;
    flush_pending_d = flush_pending_q;

    case (state_q)
      IDLE:  if (accept) state_d = ISSUE;
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = LAT_LOAD;
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (rsp_cycle) state_d = accept ? ISSUE : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      owner_d = grant_ls ? OWN_LS : OWN_IF;
      addr_d  = grant_ls ? ls_addr : if_addr;
      wren_d  = grant_ls && ls_wren;
      wdata_d = grant_ls ? ls_wdata : '0;
      bmask_d = grant_ls ? ls_bmask : 4'h0;
    end

    // A flush in the response cycle only kills that response; it never carries to the next fetch
    if (rsp_cycle) begin
      flush_pending_d = 1'b0;
    end else if (if_flush && (((owner_q == OWN_IF) && (state_q != IDLE)) || grant_if)) begin
      flush_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      owner_q         <= OWN_IF;
      addr_q          <= '0;
      wren_q          <= 1'b0;
      wdata_q         <= '0;
      bmask_q         <= 4'h0;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      owner_q         <= owner_d;
      addr_q          <= addr_d;
      wren_q          <= wren_d;
      wdata_q         <= wdata_d;
      bmask_q         <= bmask_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  always_comb begin
    if_req_ready = grant_if;
    ls_req_ready = grant_ls;
    mem_en       = (state_q == ISSUE);
    mem_wren     = mem_en && wren_q;
    mem_addr     = addr_q;
    mem_wdata    = wdata_q;
    mem_bmask    = bmask_q;
    if_rsp_valid = rsp_cycle && (owner_q == OWN_IF) && !flush_pending_q && !if_flush;
    if_rsp_data  = if_rsp_valid ? mem_rdata : '0;
    ls_rsp_valid = rsp_cycle && (owner_q == OWN_LS);
    ls_rsp_data  = (ls_rsp_valid && !wren_q) ? mem_rdata : '0;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized bench for mem_arbiter against a transaction-level reference model
module tb_mem_arbiter;
  localparam int LAT  = 3;
  localparam int SMAX = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid, if_req_ready, if_flush, if_rsp_valid;
  logic [31:0] if_addr, if_rsp_data;
  logic        ls_req_valid, ls_req_ready, ls_wren, ls_rsp_valid;
  logic [31:0] ls_addr, ls_wdata, ls_rsp_data;
  logic [3:0]  ls_bmask;
  logic        mem_en, mem_wren;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_bmask;

  int checks   = 0;
  int failures = 0;

  bit          busy, m_own_ls, m_wren, m_flushed;
  int          cyc, acc_cyc, starve, last_win;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_bmask;
  int          grants[$];
  int          gcyc[$];

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_wren(ls_wren), .ls_wdata(ls_wdata), .ls_bmask(ls_bmask),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .mem_en(mem_en), .mem_wren(mem_wren), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_bmask(mem_bmask), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_mem_en"},    64'(mem_en),       64'(0));
    check({pfx, "_mem_wren"},  64'(mem_wren),     64'(0));
    check({pfx, "_mem_addr"},  64'(mem_addr),     64'(0));
    check({pfx, "_mem_wdata"}, 64'(mem_wdata),    64'(0));
    check({pfx, "_mem_bmask"}, 64'(mem_bmask),    64'(0));
    check({pfx, "_if_rsp"},    64'(if_rsp_valid), 64'(0));
    check({pfx, "_ls_rsp"},    64'(ls_rsp_valid), 64'(0));
  endtask

  task automatic model_reset;
    busy = 0; m_flushed = 0; starve = 0; last_win = 0;
  endtask

  // One transaction occupies the port from accept cycle A; issue is A+1, response A+1+LAT.
  task automatic model_cycle;
    bit issue, resp, arb, exp_ifv, exp_lsv;
    int win;
    issue = busy && (cyc == acc_cyc + 1);
    resp  = busy && (cyc == acc_cyc + 1 + LAT);
    arb   = !busy || resp;
    win   = 0;
    if (arb) begin
      if (ls_req_valid && !(starve == SMAX && if_req_valid)) win = 2;
      else if (if_req_valid) win = 1;
    end
    check("if_req_ready", 64'(if_req_ready), 64'(win == 1));
    check("ls_req_ready", 64'(ls_req_ready), 64'(win == 2));
    check("mem_en",       64'(mem_en),       64'(issue));
    check("mem_wren",     64'(mem_wren),     64'(issue && m_wren));
    if (busy) begin
      check("mem_addr",  64'(mem_addr),  64'(m_addr));
      check("mem_bmask", 64'(mem_bmask), 64'(m_bmask));
      if (m_wren) check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    end
    exp_ifv = resp && !m_own_ls && !m_flushed && !if_flush;
    exp_lsv = resp && m_own_ls;
    check("if_rsp_valid", 64'(if_rsp_valid), 64'(exp_ifv));
    check("ls_rsp_valid", 64'(ls_rsp_valid), 64'(exp_lsv));
    if (exp_ifv) check("if_rsp_data", 64'(if_rsp_data), 64'(mem_rdata));
    if (exp_lsv) check("ls_rsp_data", 64'(ls_rsp_data), m_wren ? 64'(0) : 64'(mem_rdata));

    if (busy && !resp && !m_own_ls && if_flush) m_flushed = 1;
    if (arb) begin
      if (if_req_valid && win == 2) starve = (starve + 1 > SMAX) ? SMAX : starve + 1;
      else starve = 0;
    end
    if (resp) begin
      busy = 0;
      m_flushed = 0;
    end
    if (win != 0) begin
      busy      = 1;
      acc_cyc   = cyc;
      m_own_ls  = (win == 2);
      m_addr    = (win == 2) ? ls_addr : if_addr;
      m_wren    = (win == 2) && ls_wren;
      m_wdata   = ls_wdata;
      m_bmask   = (win == 2) ? ls_bmask : 4'h0;
      m_flushed = (win == 1) && if_flush && !resp;
    end
    last_win = win;
    cyc++;
  endtask

  // mode 0: random traffic, 1: both requesters always valid (loads), 2: quiet
  task automatic drive(input int mode);
    if (mode == 2) begin
      if_req_valid = 1'b0;
      ls_req_valid = 1'b0;
      if_flush     = 1'b0;
    end else begin
      if (!if_req_valid || last_win == 1) begin
        if_req_valid = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        if_addr      = $urandom & 32'hFFFF_FFFC;
      end
      if (!ls_req_valid || last_win == 2) begin
        ls_req_valid = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        ls_addr      = $urandom;
        ls_wren      = (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        ls_wdata     = $urandom;
        ls_bmask     = 4'($urandom);
      end
      if_flush = (mode == 0) && ($urandom_range(0, 5) == 0);
    end
    mem_rdata = $urandom;
  endtask

  task automatic step(input int mode);
    @(posedge clk);
    #1;
    drive(mode);
    @(negedge clk);
    model_cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    if_req_valid = 1'b0; if_addr = '0; if_flush = 1'b0;
    ls_req_valid = 1'b0; ls_addr = '0; ls_wren = 1'b0; ls_wdata = '0; ls_bmask = '0;
    mem_rdata = '0;
    cyc = 0; acc_cyc = 0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Starvation: both always valid from a fresh reset
    for (int i = 0; i < 100 && grants.size() < 8; i++) begin
      step(1);
      if (if_req_ready) begin grants.push_back(1); gcyc.push_back(cyc); end
      else if (ls_req_ready) begin grants.push_back(2); gcyc.push_back(cyc); end
    end
    check("starve_grant_count", 64'(grants.size()), 64'(8));
    for (int i = 0; i < grants.size(); i++) begin
      check($sformatf("starve_order_%0d", i), 64'(grants[i]), 64'((i % 4 == 3) ? 1 : 2));
      if (i > 0) check($sformatf("starve_spacing_%0d", i), 64'(gcyc[i] - gcyc[i-1]), 64'(LAT + 1));
    end

    // Asynchronous reset while a load is waiting on memory
    for (int i = 0; i < 20 && busy; i++) step(2);
    check("drain_idle", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
    ls_req_valid = 1'b1; ls_addr = 32'h100; ls_wren = 1'b0; ls_wdata = '0; ls_bmask = 4'hF;
    if_req_valid = 1'b0; if_flush = 1'b0; mem_rdata = $urandom;
    @(negedge clk);
    model_cycle();
    step(2);
    step(2);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) step(2);

    for (int i = 0; i < 3000; i++) step(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported unified instruction/data memory between two requesters: instruction fetch (IF) and load/store unit (LS).
- Accepts one transaction at a time over valid/ready handshakes, drives the memory port, and counts the fixed read latency.
- Returns a one-cycle response pulse to the owning requester.
- Sits between the fetch stage / LSU and the memory macro. Enables moving the core from single-cycle to multi-cycle operation.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..4
- STARVE_MAX, 3, consecutive IF arbitration losses after which IF wins the next arbitration; legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  AW  fetch address
- if_flush  in  1  discard pending fetch response (taken branch/jump)
- if_rsp_valid  out  1  fetch data valid pulse
- if_rsp_data  out  DW  fetch data
- ls_req_valid  in  1  load/store request
- ls_req_ready  out  1  LS request accepted this cycle
- ls_addr  in  AW  LS address
- ls_wren  in  1  1 = store, 0 = load
- ls_wdata  in  DW  store data
- ls_bmask  in  4  store byte enables
- ls_rsp_valid  out  1  load data / store ack pulse
- ls_rsp_data  out  DW  load data; 0 for store ack
- mem_en  out  1  memory access strobe
- mem_wren  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_bmask  out  4  memory byte enables
- mem_rdata  in  DW  memory read data

Behaviour:
- Clock and reset: one clock domain (clk). rst_n is asynchronous, active-low.
- Reset values:
  - FSM = IDLE.
  - All mem_* outputs = 0; both rsp_valid = 0.
  - Latency counter = 0, starvation counter = 0, owner = IF, flush_pending = 0.
- FSM states: IDLE, ISSUE, WAIT.
- Arbitration: happens only when state is IDLE, or WAIT with the counter at 1 (the response cycle).
  - Winner = LS if ls_req_valid, unless starve_cnt == STARVE_MAX with if_req_valid; then IF wins.
  - If only one requester is valid, it wins.
  - req_ready is combinational and asserted only to the winner in an arbitration cycle.
  - The handshake completes when valid and ready are both 1.
- Accept (cycle T):
  - Latch owner, addr, wren (IF is always read), wdata and bmask (IF: bmask 0).
  - Next state = ISSUE.
- ISSUE (cycle T+1):
  - mem_en = 1; mem_* = latched fields. This is the only cycle with mem_en = 1 for the transaction.
  - Load counter = MEM_LAT; next state = WAIT.
- WAIT:
  - Counter decrements each cycle. mem_en = 0; mem_addr/mem_wdata/mem_bmask hold their values; mem_wren = 0.
  - When counter == 1, this is the response cycle (T+1+MEM_LAT):
    - The owner's rsp_valid = 1 for exactly one cycle.
    - rsp_data = mem_rdata (combinational) for loads/fetch, 0 for stores.
    - Next state = ISSUE if a new request is accepted this same cycle, else IDLE.
- Throughput: back-to-back transactions complete every MEM_LAT+1 cycles. Requesters must hold valid and payload stable until ready. There is no response back-pressure.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) when IF is valid in an arbitration cycle and LS wins.
  - Clears when IF wins, or when IF is not valid in an arbitration cycle.
- Flush:
  - if_flush sampled high while the owner is IF and state is ISSUE or WAIT: set flush_pending. The memory access completes, but if_rsp_valid is suppressed in the response cycle.
  - if_flush in the accept cycle of an IF request also sets flush_pending.
  - if_flush in IDLE, or while LS owns the port: no effect.
  - flush_pending clears at the response cycle.
- Simultaneous events: a response and a new accept in the same cycle are legal.
  - A flush in the response cycle suppresses that response only.
- Reset mid-transaction: immediate return to reset values. The outstanding transaction is dropped and no response is issued.
- Width rules:
  - Counter width = clog2(MEM_LAT+1).
  - Starvation counter width = clog2(STARVE_MAX+1).
  - MEM_LAT outside 1..4 is a fatal elaboration error.

Decomposition:
- Shared package riscv_pkg holds:
  - the FSM state encoding (IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2);
  - the owner encoding (OWN_IF = 1'b0, OWN_LS = 1'b1);
  - the width constants AW and DW.
- One sub-module, arb_prio, holds the combinational winner selection and the starvation counter. The FSM, latches and response muxing stay in mem_arbiter.

Test Plan:
- Single load, MEM_LAT=1: LS valid, addr 0x100, mem_rdata=0xDEADBEEF at T+2 -> ls_req_ready at T; mem_en only at T+1 with mem_addr 0x100; ls_rsp_valid at T+2 with 0xDEADBEEF; if_rsp_valid stays 0.
- Store ack: LS store to 0x20, wdata 0x12345678, bmask 0xF -> mem_wren=1 for one cycle at T+1; ls_rsp_valid at T+2 with ls_rsp_data=0.
- Starvation, STARVE_MAX=3: both requesters valid continuously -> grant order LS, LS, LS, IF, LS, LS, LS, IF; one grant every MEM_LAT+1 cycles.
- Flush: IF fetch to 0x40 accepted, if_flush pulsed at T+1 -> mem_en still asserted at T+1; if_rsp_valid never asserted; next IF fetch to 0x44 returns normally.
- MEM_LAT=3 back-to-back: two IF fetches -> mem_en at T+1 and T+5; if_rsp_valid at T+4 and T+8; second accept at T+4.
- Async reset: assert rst_n=0 in WAIT -> all outputs 0 immediately; after release no stale rsp_valid; next request serviced normally.
